// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: request op codes, ALU control codes
// and FSM states.
package alu_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SLT  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTRL_NOP = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Map a request op onto the ALU control code; reserved ops drive NOP.
    function automatic logic [3:0] ctrl_of(input op_e op);
        case (op)
            OP_ADD:  ctrl_of = ALU_CTRL_ADD;
            OP_SUB:  ctrl_of = ALU_CTRL_SUB;
            OP_SLT:  ctrl_of = ALU_CTRL_SLT;
            default: ctrl_of = ALU_CTRL_NOP;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. A lone valid always wins; with both valid the
// requester that did not win last time gets the grant. Purely combinational.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant from the valids and the previous winner's id.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. A request is accepted
// in IDLE, its operands drive the ALU for one EXEC cycle, and the registered
// result is held in RESP until the granted requester takes it.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [1:0]   r0_op,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r0_b,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [1:0]   r1_op,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r1_b,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic [W-1:0] alu_src1,
    output logic [W-1:0] alu_src2,
    output logic [3:0]   alu_ctrl,
    input  logic [W-1:0] alu_result
);

    state_e         state_q, state_d;
    logic           last_grant_q;
    logic [1:0]     grant;
    logic           hs;
    logic           id_q;
    op_e            op_q;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   rsp_data_q;
    logic           rsp_err_q;

    rr_arb2 u_arb (
        .valid      ({r1_valid, r0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // grant is only non-zero when the granted requester is valid
    assign hs = (state_q == ST_IDLE) && (grant != 2'b00);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: EXEC lasts one cycle, RESP waits on the granted rsp_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hs)            state_d = ST_EXEC;
            ST_EXEC:                    state_d = ST_RESP;
            ST_RESP: if (rsp_ready[id_q]) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request ready, response valid, ALU control
    always_comb begin
        r0_ready  = (state_q == ST_IDLE) && grant[0];
        r1_ready  = (state_q == ST_IDLE) && grant[1];
        rsp_valid = 2'b00;
        alu_ctrl  = ALU_CTRL_NOP;
        if (state_q == ST_RESP) rsp_valid[id_q] = 1'b1;
        if (state_q == ST_EXEC) alu_ctrl = ctrl_of(op_q);
    end

    // Capture the winning request and remember who won for round-robin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
        end else if (hs) begin
            last_grant_q <= grant[1];
            id_q         <= grant[1];
            op_q         <= grant[1] ? op_e'(r1_op) : op_e'(r0_op);
            a_q          <= grant[1] ? r1_a : r0_a;
            b_q          <= grant[1] ? r1_b : r0_b;
        end
    end

    // Register the ALU result at the end of EXEC; reserved ops return 0 + err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_data_q <= (op_q == OP_RSVD) ? '0 : alu_result;
            rsp_err_q  <= (op_q == OP_RSVD);
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign alu_src1 = a_q;
    assign alu_src2 = b_q;

endmodule
